// File: rtl/ram_ctrl_pkg.sv
// ram_ctrl_pkg: shared definitions for the RAM request front-end.
// Contents: RAM geometry (data width, address width, depth) and the
//           controller state encoding shared by the controller and its users.
package ram_ctrl_pkg;

  localparam int RAM_DATA_W = 32;
  localparam int RAM_ADDR_W = 5;
  localparam int RAM_DEPTH  = 32;

  // Controller states: zero-fill walk, ready for requests, holding a read response.
  typedef enum logic [1:0] {
    ST_CLEAR = 2'd0,
    ST_IDLE  = 2'd1,
    ST_RESP  = 2'd2
  } state_t;

endpackage

// File: rtl/ram_req_ctrl.sv
// ram_req_ctrl: request front-end placed directly upstream of a single-port RAM.
//   Turns a valid/ready request stream (read/write, addr, wdata) into RAM
//   wr/rd/addr/data_in strobes and returns read data on a valid/ready
//   response channel. Also owns the RAM zero fill: after reset or on clr_req
//   it walks every address writing zero, because the RAM's own reset only
//   clears the single addressed word.
// Ports:
//   clk, rst            clock; synchronous active-high reset
//   clr_req             pulse requesting a full-RAM zero fill
//   busy                high while the zero-fill walk runs
//   req_valid/req_ready request handshake; req_we, req_addr, req_wdata payload
//   rsp_valid/rsp_ready read-response handshake; rsp_data payload
//   mem_wr, mem_rd, mem_addr, mem_wdata   strobes to the RAM
//   mem_rdata           combinational RAM read data (valid while mem_rd=1)
module ram_req_ctrl
  import ram_ctrl_pkg::*;
#(
  parameter int DATA_W = RAM_DATA_W,
  parameter int ADDR_W = RAM_ADDR_W,
  parameter int DEPTH  = RAM_DEPTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr_req,
  output logic              busy,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              mem_wr,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  state_t              state_r;
  logic [ADDR_W-1:0]   clr_cnt_r;
  logic                clr_pend_r;
  logic                rsp_valid_r;
  logic [DATA_W-1:0]   rsp_data_r;
  logic                accept_s;

  assign busy      = (state_r == ST_CLEAR);
  // A clear request takes the IDLE cycle away from any pending request.
  assign req_ready = (state_r == ST_IDLE) && !clr_req;
  assign accept_s  = req_valid && req_ready;
  assign rsp_valid = rsp_valid_r;
  assign rsp_data  = rsp_data_r;

  // RAM strobe decode: walk address during clear, pass accepted request through in IDLE.
  always_comb begin
    mem_wr    = 1'b0;
    mem_rd    = 1'b0;
    mem_addr  = {ADDR_W{1'b0}};
    mem_wdata = {DATA_W{1'b0}};
    case (state_r)
      ST_CLEAR: begin
        mem_wr   = 1'b1;
        mem_addr = clr_cnt_r;
      end
      ST_IDLE: begin
        if (accept_s) begin
          mem_addr = req_addr;
          if (req_we) begin
            mem_wr    = 1'b1;
            mem_wdata = req_wdata;
          end else begin
            mem_rd = 1'b1;
          end
        end else begin
          mem_addr = {ADDR_W{1'b0}};
        end
      end
      ST_RESP: begin
        mem_wr = 1'b0;
      end
      default: begin
        mem_wr = 1'b0;
      end
    endcase
  end

  // Controller FSM: clear walk counter, response register and deferred clear flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_CLEAR;
      clr_cnt_r   <= {ADDR_W{1'b0}};
      clr_pend_r  <= 1'b0;
      rsp_valid_r <= 1'b0;
      rsp_data_r  <= {DATA_W{1'b0}};
    end else begin
      case (state_r)
        ST_CLEAR: begin
          if (clr_cnt_r == ADDR_W'(DEPTH - 1)) begin
            clr_cnt_r <= {ADDR_W{1'b0}};
            state_r   <= ST_IDLE;
          end else begin
            clr_cnt_r <= clr_cnt_r + ADDR_W'(1);
          end
        end
        ST_IDLE: begin
          if (clr_req) begin
            state_r <= ST_CLEAR;
          end else if (accept_s && !req_we) begin
            // RAM read data is combinational; capture it at the accept edge.
            rsp_data_r  <= mem_rdata;
            rsp_valid_r <= 1'b1;
            state_r     <= ST_RESP;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid_r <= 1'b0;
            clr_pend_r  <= 1'b0;
            // A clear arriving on the handshake cycle itself must not be lost either.
            state_r     <= (clr_pend_r || clr_req) ? ST_CLEAR : ST_IDLE;
          end else if (clr_req) begin
            clr_pend_r <= 1'b1;
          end else begin
            clr_pend_r <= clr_pend_r;
          end
        end
        default: begin
          state_r   <= ST_CLEAR;
          clr_cnt_r <= {ADDR_W{1'b0}};
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ram_req_ctrl.sv
// tb_ram_req_ctrl: self-checking bench for ram_req_ctrl with a behavioural
//   32x32 RAM attached to the mem_* ports. Expected read data comes from a
//   reference memory that the bench updates from accepted writes and clears.
module tb_ram_req_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clr_req = 1'b0;
  logic        busy;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [4:0]  req_addr = 5'd0;
  logic [31:0] req_wdata = 32'h0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_data;
  logic        mem_wr;
  logic        mem_rd;
  logic [4:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  logic [31:0] tb_ram  [32];
  logic [31:0] ref_mem [32];
  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  ram_req_ctrl dut (
    .clk(clk), .rst(rst), .clr_req(clr_req), .busy(busy),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .mem_wr(mem_wr), .mem_rd(mem_rd), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // Behavioural RAM: garbage while rst is high so the zero fill is observable.
  always @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < 32; k++) tb_ram[k] <= $urandom;
    end else if (mem_wr) begin
      tb_ram[mem_addr] <= mem_wdata;
    end
  end
  assign mem_rdata = mem_rd ? tb_ram[mem_addr] : 32'h0;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Expect a 32-cycle zero walk starting at address 0, then IDLE.
  task automatic check_walk(input string tag);
    for (int i = 0; i < 32; i++) begin
      checks++;
      if ({busy, req_ready, mem_wr, mem_rd} !== 4'b1010 || mem_addr !== 5'(i) || mem_wdata !== 32'h0) begin
        errors++;
        $display("FAIL %s walk[%0d]: busy=%b rdy=%b wr=%b rd=%b addr=%0d wdata=%h, want 1 0 1 0 addr=%0d wdata=0",
                 tag, i, busy, req_ready, mem_wr, mem_rd, mem_addr, mem_wdata, i);
      end
      @(posedge clk); #1;
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL %s walk_end: busy=%b want 0", tag, busy);
    end
    for (int i = 0; i < 32; i++) ref_mem[i] = 32'h0;
  endtask

  task automatic do_write(input logic [4:0] a, input logic [31:0] d);
    req_valid = 1'b1; req_we = 1'b1; req_addr = a; req_wdata = d;
    #1;
    checks++;
    if ({req_ready, mem_wr, mem_rd} !== 3'b110 || mem_addr !== a || mem_wdata !== d) begin
      errors++;
      $display("FAIL write_accept: rdy=%b wr=%b rd=%b addr=%0d wdata=%h, want 1 1 0 addr=%0d wdata=%h",
               req_ready, mem_wr, mem_rd, mem_addr, mem_wdata, a, d);
    end
    @(posedge clk); #1;
    req_valid = 1'b0; req_we = 1'b0;
    ref_mem[a] = d;
  endtask

  task automatic do_read(input logic [4:0] a, input int hold);
    logic [31:0] exp;
    exp = ref_mem[a];
    req_valid = 1'b1; req_we = 1'b0; req_addr = a;
    #1;
    checks++;
    if ({req_ready, mem_wr, mem_rd} !== 3'b101 || mem_addr !== a) begin
      errors++;
      $display("FAIL read_accept: rdy=%b wr=%b rd=%b addr=%0d, want 1 0 1 addr=%0d",
               req_ready, mem_wr, mem_rd, mem_addr, a);
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    for (int h = 0; h <= hold; h++) begin
      checks++;
      if (rsp_valid !== 1'b1 || rsp_data !== exp || req_ready !== 1'b0 || mem_wr !== 1'b0 || mem_rd !== 1'b0) begin
        errors++;
        $display("FAIL read_rsp[%0d] addr=%0d: valid=%b data=%h rdy=%b wr=%b rd=%b, want 1 %h 0 0 0",
                 h, a, rsp_valid, rsp_data, req_ready, mem_wr, mem_rd, exp);
      end
      if (h < hold) begin
        @(posedge clk); #1;
      end
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    checks++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL read_done addr=%0d: valid=%b rdy=%b busy=%b, want 0 1 0", a, rsp_valid, req_ready, busy);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    checks++;
    if (rsp_valid !== 1'b0 || rsp_data !== 32'h0) begin
      errors++;
      $display("FAIL reset_rsp: valid=%b data=%h want 0 0", rsp_valid, rsp_data);
    end
    check_walk("reset");
    do_read(5'd5, 0);
  endtask

  task automatic test_write_read();
    do_write(5'd7, 32'hDEADBEEF);
    do_read(5'd7, 0);
  endtask

  task automatic test_backpressure();
    do_read(5'd7, 3);
  endtask

  task automatic test_clr_collision();
    logic [31:0] d;
    d = $urandom;
    clr_req = 1'b1; req_valid = 1'b1; req_we = 1'b1; req_addr = 5'd3; req_wdata = d;
    #1;
    checks++;
    if (req_ready !== 1'b0 || mem_wr !== 1'b0) begin
      errors++;
      $display("FAIL clr_collision: rdy=%b wr=%b want 0 0", req_ready, mem_wr);
    end
    @(posedge clk); #1;
    clr_req = 1'b0;
    check_walk("clr_collision");
    // The request stayed valid through the walk; it goes in on the first IDLE cycle.
    do_write(5'd3, d);
    do_read(5'd3, 0);
  endtask

  task automatic test_clr_in_resp();
    do_write(5'd7, $urandom | 32'h1);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 5'd7;
    @(posedge clk); #1;
    req_valid = 1'b0;
    clr_req = 1'b1;
    @(posedge clk); #1;
    clr_req = 1'b0;
    repeat (2) begin
      checks++;
      if (rsp_valid !== 1'b1 || busy !== 1'b0 || rsp_data !== ref_mem[7]) begin
        errors++;
        $display("FAIL clr_in_resp_hold: valid=%b busy=%b data=%h want 1 0 %h", rsp_valid, busy, rsp_data, ref_mem[7]);
      end
      @(posedge clk); #1;
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    checks++;
    if (rsp_valid !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL clr_in_resp_handshake: valid=%b busy=%b want 0 1", rsp_valid, busy);
    end
    check_walk("clr_in_resp");
    do_read(5'd7, 0);
  endtask

  task automatic test_rst_mid();
    do_write(5'd9, $urandom | 32'h1);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 5'd9;
    @(posedge clk); #1;
    req_valid = 1'b0;
    clr_req = 1'b1;  // leaves a deferred clear that reset must discard
    @(posedge clk); #1;
    clr_req = 1'b0;
    checks++;
    if (rsp_valid !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid_pre: valid=%b want 1", rsp_valid);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++;
    if (rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_drop: valid=%b want 0", rsp_valid);
    end
    check_walk("rst_mid");
    // do_read also confirms the handshake returns to IDLE (deferred clear gone).
    do_read(5'd9, 1);
  endtask

  task automatic test_random();
    for (int n = 0; n < 200; n++) begin
      int op;
      op = $urandom_range(0, 4);
      if (op <= 1) begin
        do_write(5'($urandom_range(0, 31)), $urandom);
      end else if (op <= 3) begin
        do_read(5'($urandom_range(0, 31)), $urandom_range(0, 2));
      end else begin
        #1;
        checks++;
        if (mem_wr !== 1'b0 || mem_rd !== 1'b0 || mem_addr !== 5'd0 || req_ready !== 1'b1) begin
          errors++;
          $display("FAIL idle: wr=%b rd=%b addr=%0d rdy=%b want 0 0 0 1", mem_wr, mem_rd, mem_addr, req_ready);
        end
        @(posedge clk); #1;
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) ref_mem[i] = 32'h0;
    test_reset();
    test_write_read();
    test_backpressure();
    test_clr_collision();
    test_clr_in_resp();
    test_rst_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
